// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory load/store controller.
package cpu_mem_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bus command latched on acceptance and held for the whole transaction.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  // Stores only have B/H/W; loads add the unsigned BU/HU variants.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cpu_mem_lane_align.sv
// Byte-lane steering: byte enables, store-data replication, load shift and
// alignment check for a word-organised data bus.
module cpu_mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      rd_off_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misaligned_o
);

  always_comb begin
    be_o         = '0;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = BE_W'(4'b0001 << off_i);
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o         = BE_W'(4'b0011 << off_i);
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = off_i[0];
      end
      F3_W: begin
        be_o         = '1;
        wdata_o      = store_data_i;
        misaligned_o = |off_i;
      end
      default: begin
        be_o         = '0;
        wdata_o      = store_data_i;
        misaligned_o = 1'b0;
      end
    endcase
  end

  // Load lane uses the offset captured at acceptance, not the live address.
  assign rdata_o = rdata_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/cpu_data_mem_ctrl.sv
// Load/store bus controller: accepts one aligned access, drives a word-aligned
// request with byte enables, stalls the pipeline until ack or timeout.
module cpu_data_mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              bus_error_q, bus_error_d;
  logic              mem_req_q, mem_req_d;

  logic [BE_W-1:0]   be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   rdata_shift_c;
  logic              misal_c;
  logic              access_c;
  logic              accept_c;

  cpu_mem_lane_align u_lane_align (
    .funct3_i     (funct3),
    .off_i        (addr[1:0]),
    .rd_off_i     (off_q),
    .store_data_i (store_data),
    .rdata_i      (mem_rdata),
    .be_o         (be_c),
    .wdata_o      (wdata_c),
    .rdata_o      (rdata_shift_c),
    .misaligned_o (misal_c)
  );

  // Illegal funct3 is a silent no-op: neither accepted nor flagged.
  assign access_c   = (load | store) & f3_legal(store, funct3);
  assign accept_c   = (state_q == IDLE) & access_c & ~misal_c;
  assign misaligned = (state_q == IDLE) & access_c & misal_c;
  assign stall      = ~rst & (accept_c | (state_q == REQ));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    off_d        = off_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_error_d  = 1'b0;
    mem_req_d    = mem_req_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cmd_d.we    = store;
          cmd_d.addr  = {addr[31:2], 2'b00};
          cmd_d.be    = be_c;
          cmd_d.wdata = store ? wdata_c : '0;
          off_d       = addr[1:0];
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!cmd_q.we) begin
            load_data_d  = rdata_shift_c;
            load_valid_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          mem_req_d   = 1'b0;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      off_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
      mem_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      off_q        <= off_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_error_q  <= bus_error_d;
      mem_req_q    <= mem_req_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = cmd_q.we;
  assign mem_addr   = cmd_q.addr;
  assign mem_be     = cmd_q.be;
  assign mem_wdata  = cmd_q.wdata;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_error  = bus_error_q;

endmodule
